// File: rtl/one_hot_arb_pkg.sv
// Shared types and limits for the one-hot round-robin arbiter.
// Holds no per-instance parameters; widths are set by each instance.
package one_hot_arb_pkg;

    localparam int unsigned ARB_CNT_MIN = 2;
    localparam int unsigned ARB_CNT_MAX = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/one_hot_rr_arb_pri_pick.sv
// Rotating-priority picker: first set bit of (req & ~mask), searching from ptr
// upward with wrap at CNT-1. Purely combinational.
module rr_pri_pick
    import one_hot_arb_pkg::*;
#(
    parameter int unsigned CNT  = 5,
    parameter int unsigned IDXW = $clog2(CNT)
) (
    input  logic [CNT-1:0]  req,
    input  logic [CNT-1:0]  mask,
    input  logic [IDXW-1:0] ptr,
    output logic [CNT-1:0]  pick,
    output logic [IDXW-1:0] pick_idx
);

    logic [CNT-1:0]  cand;
    logic [IDXW-1:0] pos;
    logic            found;

    always_comb begin
        cand     = req & ~mask;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        pos      = ptr;
        for (int unsigned k = 0; k < CNT; k++) begin
            if (!found && cand[pos]) begin
                found     = 1'b1;
                pick[pos] = 1'b1;
                pick_idx  = pos;
            end
            // pos never leaves 0..CNT-1, so no index past the last requester
            pos = (pos == IDXW'(CNT - 1)) ? '0 : pos + 1'b1;
        end
    end

endmodule

// File: rtl/one_hot_rr_arb.sv
// One-hot round-robin arbiter with registered grant, held until ack.
// Optional ONE_HOT_ARB_LOCK_EN adds a lock input that keeps ownership across acks.
module one_hot_rr_arb
    import one_hot_arb_pkg::*;
#(
    parameter int unsigned CNT  = 5,
    parameter int unsigned IDXW = $clog2(CNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CNT-1:0]  req,
    input  logic            ack,
`ifdef ONE_HOT_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [CNT-1:0]  gnt,
    output logic            gnt_vld,
    output logic [IDXW-1:0] gnt_idx
);

    arb_state_e      state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_adv;
    logic [IDXW-1:0] pick_ptr;
    logic [IDXW-1:0] pick_idx;
    logic [CNT-1:0]  pick;
    logic [CNT-1:0]  mask;
    logic            rel_gnt;

    assign ptr_adv = (gnt_idx == IDXW'(CNT - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef ONE_HOT_ARB_LOCK_EN
    assign rel_gnt = (state == GRANT) && ack && !lock;
`else
    assign rel_gnt = (state == GRANT) && ack;
`endif

    // On release the next pick already sees the advanced pointer and excludes
    // the outgoing owner, giving back-to-back grants without an idle bubble.
    assign pick_ptr = rel_gnt ? ptr_adv : ptr;
    assign mask     = (state == GRANT) ? gnt : '0;

    rr_pri_pick #(
        .CNT  (CNT),
        .IDXW (IDXW)
    ) u_pick (
        .req      (req),
        .mask     (mask),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|pick) begin
                        state   <= GRANT;
                        gnt     <= pick;
                        gnt_vld <= 1'b1;
                        gnt_idx <= pick_idx;
                    end
                end
                GRANT: begin
                    if (rel_gnt) begin
                        ptr <= ptr_adv;
                        if (|pick) begin
                            gnt     <= pick;
                            gnt_vld <= 1'b1;
                            gnt_idx <= pick_idx;
                        end else begin
                            state   <= IDLE;
                            gnt     <= '0;
                            gnt_vld <= 1'b0;
                            gnt_idx <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    gnt_vld <= 1'b0;
                    gnt_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/one_hot_rr_arb.md
ONE_HOT_RR_ARB -- requirements
Module: one_hot_rr_arb

Interface
REQ-001 Parameter CNT, default 5: number of requesters; legal range 2..32.
REQ-002 Parameter IDXW, default $clog2(CNT): width of gnt_idx.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  CNT  per-requester request level; bit i = requester i.
REQ-006 ack  input  1  downstream consumed the granted transfer; releases current grant.
REQ-007 gnt  output  CNT  registered grant; one-hot or all-zero; drives the one-hot mux select directly.
REQ-008 gnt_vld  output  1  registered; high when gnt is non-zero.
REQ-009 gnt_idx  output  IDXW  registered binary index of the set gnt bit; 0 when gnt_vld low.
REQ-010 lock  input  1  present only with ONE_HOT_ARB_LOCK_EN (see Configuration).

Function
REQ-011 Two states: IDLE (no grant) and GRANT (one grant held); state register, gnt, gnt_idx and priority pointer ptr all registered.
REQ-012 ptr (IDXW bits) names the highest-priority requester; priority descends ptr, ptr+1, ... CNT-1, 0, ... ptr-1, modulo CNT.
REQ-013 IDLE: if req != 0, next cycle enter GRANT with gnt = first set req bit in priority order; else remain IDLE, gnt = 0.
REQ-014 Grant latency: req asserted in cycle N (state IDLE) yields gnt at cycle N+1.
REQ-015 GRANT without ack: gnt, gnt_idx held unchanged, regardless of req changes (including granted requester dropping req).
REQ-016 GRANT with ack: ptr <= (gnt_idx+1) mod CNT; new pick evaluated same cycle with updated priority over current req masked to exclude gnt_idx; if any bit remains, next cycle GRANT with new gnt (back-to-back, no idle bubble); else IDLE with gnt = 0.
REQ-017 Wrap-around: gnt_idx = CNT-1 with ack sets ptr = 0.
REQ-018 Single requester continuously requesting: after ack, one IDLE cycle, then re-granted (mask of REQ-016 forbids immediate self-regrant).
REQ-019 ack while IDLE is ignored; no state, ptr or output change.
REQ-020 gnt is never multi-hot; gnt_vld = |gnt and gnt_idx = encode(gnt) every cycle.
REQ-021 req bits at index >= CNT do not exist; no arithmetic beyond CNT.

Reset
REQ-022 rst high at any clock edge, including mid-GRANT: state = IDLE, gnt = 0, gnt_vld = 0, gnt_idx = 0, ptr = 0; req and ack ignored that cycle.
REQ-023 First arbitration after reset release starts with requester 0 as highest priority.

Configuration
REQ-024 Macro ONE_HOT_ARB_LOCK_EN: when defined, lock port exists; ack with lock high keeps the same gnt, gnt_idx and ptr (transfer continues, multi-beat ownership); ack with lock low behaves per REQ-016.
REQ-025 When ONE_HOT_ARB_LOCK_EN undefined: no lock port; behaviour exactly REQ-016.

Structure
REQ-026 Package one_hot_arb_pkg holds state enum (IDLE, GRANT) and the priority-pick/encode function prototypes' constants; no per-instance parameters in the package.
REQ-027 One sub-module rr_pri_pick: combinational, inputs req, mask, ptr; outputs one-hot pick and pick index; instantiated once.
REQ-028 Output gnt connects to the one-hot mux sel port with no intervening logic; the mux error flag stays low for all legal operation.

Verification (CNT=5)
REQ-029 Reset, then req=5'b00100 -> gnt=5'b00100, gnt_idx=2, gnt_vld=1 exactly one cycle later; held 10 cycles with ack=0.
REQ-030 req=5'b11111 held, ack every cycle in GRANT -> gnt sequence 0,1,2,3,4,0 back-to-back, no gnt_vld gaps.
REQ-031 gnt_idx=4 granted, req=5'b10001, ack -> next gnt=5'b00001 (wrap, ptr=0).
REQ-032 req=5'b01000 only, ack -> one cycle gnt=0 then gnt=5'b01000.
REQ-033 rst asserted mid-GRANT (gnt=5'b00010) -> next cycle gnt=0, gnt_vld=0; after release, req=5'b10010 -> gnt=5'b00010.
REQ-034 With ONE_HOT_ARB_LOCK_EN, gnt=5'b00100, ack+lock for 3 cycles -> gnt unchanged; ack with lock=0 -> advance per REQ-016; random req/ack for 10k cycles -> gnt never multi-hot.
